// File: rtl/tech_map_pkg.sv
// Helpers shared by the techmap sequential-cell simulation targets.
package tech_map_pkg;

  // Width of a 0..depth occupancy counter; never narrower than one bit.
  function automatic int unsigned count_width(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tech_rff_pipe_if.sv
// Valid/ready stream bundle for the resettable flop pipeline, with flush and occupancy.
interface tech_rff_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned CntW = tech_map_pkg::count_width(DEPTH);

  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CntW-1:0]  count;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/tech_rff_stage.sv
// One WIDTH-bit pipeline stage: async reset to RST_VAL, synchronous clear, load enable.
module tech_rff_stage #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             v_o,
  output logic [WIDTH-1:0] d_o
);
  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (clr_i) begin
      v_d = 1'b0;
      d_d = RST_VAL;
    end else if (ld_i) begin
      v_d = v_i;
      // Bubbles advance the valid bit only; data keeps its last word.
      if (v_i) d_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign v_o = v_q;
  assign d_o = d_q;
endmodule

// File: rtl/tech_rff_pipe.sv
// DEPTH-stage valid/ready flop pipeline with bubble collapsing, flush and occupancy count.
module tech_rff_pipe
  import tech_map_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  tech_rff_pipe_if.slave bus
);
  localparam int unsigned CntW = count_width(DEPTH);

  logic [DEPTH-1:0] stage_v;
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             in_ready;
  logic             accept, emit;
  logic [CntW-1:0]  count_q, count_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_src;
    logic [WIDTH-1:0] d_src;

    // A stage may load when downstream drains or any slot from here to the output is empty.
    assign rdy[i] = bus.out_ready | ~(&stage_v[DEPTH-1:i]);

    if (i == 0) begin : g_head
      assign v_src = bus.in_valid;
      assign d_src = bus.in_data;
    end else begin : g_body
      assign v_src = stage_v[i-1];
      assign d_src = stage_d[i-1];
    end

    tech_rff_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .clr_i (bus.clr),
      .ld_i  (rdy[i]),
      .v_i   (v_src),
      .d_i   (d_src),
      .v_o   (stage_v[i]),
      .d_o   (stage_d[i])
    );
  end

  assign in_ready = rdy[0] & ~bus.clr;
  assign accept   = bus.in_valid & in_ready;
  assign emit     = stage_v[DEPTH-1] & bus.out_ready;

  always_comb begin
    count_d = count_q;
    if (bus.clr) begin
      count_d = '0;
    end else if (accept && !emit) begin
      count_d = count_q + CntW'(1);
    end else if (!accept && emit) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = stage_v[DEPTH-1];
  assign bus.out_data  = stage_d[DEPTH-1];
  assign bus.count     = count_q;
endmodule

// File: tb/tb_tech_rff_pipe.sv
// Bench for tech_rff_pipe: directed vector table, flush/reset sequences, randomized model check.
module tb_tech_rff_pipe;
  import tech_map_pkg::*;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 3;
  localparam logic [7:0]  RST_VAL = 8'hA5;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tech_rff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  tech_rff_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       clr;
    logic       iv;
    logic [7:0] d;
    logic       orr;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    int         cnt;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } word_t;

  // Reference model: ordered list of words with their slot position (0 = input side).
  word_t      mq[$];
  logic [7:0] m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ir, input logic ov,
                         input logic [7:0] od, input int cnt);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(ir));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'(od));
    chk({tag, ".count"}, 32'(bus.count), cnt);
  endtask

  task automatic drive(input logic c, input logic iv, input logic [7:0] d, input logic orr);
    @(negedge clk);
    bus.clr       = c;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = orr;
    #1;
  endtask

  function automatic vec_t mk(input logic c, input logic iv, input logic [7:0] d,
                              input logic orr, input logic ir, input logic ov,
                              input logic [7:0] od, input int cnt);
    vec_t v;
    v.clr = c; v.iv = iv; v.d = d; v.orr = orr;
    v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic m_in_ready(input logic c, input logic orr);
    return !c && ((mq.size() < DEPTH) || orr);
  endfunction

  function automatic logic m_out_valid();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  task automatic model_step(input logic c, input logic iv, input logic [7:0] d,
                            input logic orr);
    logic acc;
    int   limit;
    int   np;
    word_t w;
    if (c) begin
      mq.delete();
      m_last = RST_VAL;
    end else begin
      acc = iv && m_in_ready(c, orr);
      if (m_out_valid() && orr) void'(mq.pop_front());
      limit = DEPTH - 1;
      foreach (mq[i]) begin
        np = (mq[i].pos + 1 < limit) ? mq[i].pos + 1 : limit;
        if (np != mq[i].pos && np == DEPTH - 1) m_last = mq[i].data;
        mq[i].pos = np;
        limit = np - 1;
      end
      if (acc) begin
        w.data = d;
        w.pos  = 0;
        mq.push_back(w);
        if (DEPTH == 1) m_last = d;
      end
    end
  endtask

  initial begin
    vec_t       vecs[$];
    logic       c, iv, orr;
    logic [7:0] d;

    reset         = 1'b1;
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state before any clock edge.
    #3;
    chk_out("reset0", 1'b1, 1'b0, RST_VAL, 0);
    @(negedge clk);
    reset = 1'b0;

    //                 clr iv  data   ordy | ir  ov  odata  cnt
    // Stream at full rate.
    vecs.push_back(mk(0, 1, 8'h11, 1,  1, 0, RST_VAL, 0));
    vecs.push_back(mk(0, 1, 8'h22, 1,  1, 0, RST_VAL, 1));
    vecs.push_back(mk(0, 1, 8'h33, 1,  1, 0, RST_VAL, 2));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h11,   3));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h22,   2));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h33,   1));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 0, 8'h33,   0));
    // Backpressure: fourth word refused, then drain in order.
    vecs.push_back(mk(0, 1, 8'h51, 0,  1, 0, 8'h33,   0));
    vecs.push_back(mk(0, 1, 8'h52, 0,  1, 0, 8'h33,   1));
    vecs.push_back(mk(0, 1, 8'h53, 0,  1, 0, 8'h33,   2));
    vecs.push_back(mk(0, 1, 8'h54, 0,  0, 1, 8'h51,   3));
    vecs.push_back(mk(0, 1, 8'h54, 0,  0, 1, 8'h51,   3));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h51,   3));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h52,   2));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h53,   1));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 0, 8'h53,   0));
    // Bubble collapse: A, idle, B with output stalled.
    vecs.push_back(mk(0, 1, 8'h61, 0,  1, 0, 8'h53,   0));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 0, 8'h53,   1));
    vecs.push_back(mk(0, 1, 8'h62, 0,  1, 0, 8'h53,   1));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 1, 8'h61,   2));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 1, 8'h61,   2));
    // Fill, then simultaneous accept and emit while full.
    vecs.push_back(mk(0, 1, 8'h63, 0,  1, 1, 8'h61,   2));
    vecs.push_back(mk(0, 1, 8'h44, 1,  1, 1, 8'h61,   3));
    vecs.push_back(mk(0, 0, 8'h00, 0,  0, 1, 8'h62,   3));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h62,   3));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h63,   2));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h44,   1));
    vecs.push_back(mk(0, 0, 8'h00, 0,  1, 0, 8'h44,   0));

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].orr);
      chk_out($sformatf("vec%0d", i), vecs[i].ir, vecs[i].ov, vecs[i].od, vecs[i].cnt);
    end

    // Synchronous flush with a valid word presented on the output.
    drive(0, 1, 8'h71, 0);
    drive(0, 1, 8'h72, 0);
    drive(0, 0, 8'h00, 0);
    chk_out("clr_pre", 1'b1, 1'b0, 8'h44, 2);
    drive(0, 0, 8'h00, 0);
    chk_out("clr_pre2", 1'b1, 1'b1, 8'h71, 2);
    drive(1, 1, 8'h73, 1);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    drive(0, 0, 8'h00, 0);
    chk_out("clr_post", 1'b1, 1'b0, RST_VAL, 0);

    // Async reset mid-cycle with words in flight.
    drive(0, 1, 8'h81, 0);
    drive(0, 1, 8'h82, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    chk_out("rst_pre", 1'b1, 1'b1, 8'h81, 2);
    #2;
    reset = 1'b1;
    #1;
    chk_out("rst_async", 1'b1, 1'b0, RST_VAL, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the reference model.
    mq.delete();
    m_last = RST_VAL;
    for (int n = 0; n < 600; n++) begin
      c   = ($urandom_range(0, 24) == 0);
      iv  = ($urandom_range(0, 9) < 6);
      d   = 8'($urandom);
      orr = (n < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      drive(c, iv, d, orr);
      chk_out($sformatf("rnd%0d", n), m_in_ready(c, orr), m_out_valid(), m_last,
              mq.size());
      model_step(c, iv, d, orr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
